dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised successor to the single-cycle data memory: byte-addressable, little-endian, 32-bit data path, same sub-word load/store encodings.
- Adds a valid/ready request/response handshake, configurable read latency, and fault reporting for misaligned, out-of-range and illegal accesses.
- Sits between the LSU/MEM stage and backing storage; supports exactly one outstanding transaction.

Parameters:
- DEPTH_BYTES, 1024: memory size in bytes; multiple of 4, power of two.
- ADDR_WIDTH, 32: request address width.
- LATENCY, 2: cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_mem_read  in  3  [1:0]: 01 byte, 10 half, 11 word; [2]=1 sign-extend; 000 = no load.
- req_mem_write  in  2  01 byte, 10 half, 11 word, 00 = no store.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  load result, extended per req_mem_read[2]; 0 for stores and faults.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal op.

Behaviour:
- Reset: go to IDLE; req_ready=0 during the reset cycle, then 1; rsp_valid=0, rsp_rdata=0, rsp_fault=00. Memory contents are not cleared.
- Reset asserted in any state aborts the transaction immediately; no response is issued. A store already committed stays committed.
- FSM IDLE -> WAIT -> RESP -> IDLE. req_ready=1 only in IDLE.
- Acceptance: edge with req_valid && req_ready. Latch the request and load counter = LATENCY-1.
  - Counter 0 -> RESP next edge.
  - Otherwise -> WAIT; decrement each cycle; -> RESP when counter reaches 0.
- rsp_valid rises exactly LATENCY cycles after the acceptance edge.
- Fault checks, in priority order:
  - 11 illegal: both fields nonzero, both zero, or req_mem_read[1:0]=00 with req_mem_read[2]=1.
  - 10 out of range: addr + size - 1 >= DEPTH_BYTES.
  - 01 misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Faulting requests never write memory, return rdata=0, and use the same latency.
- Stores commit at the acceptance edge, so any later load sees the new data. Store responses return rdata=0.
- Load data is sampled from memory on the edge that enters RESP.
- RESP: hold rsp_valid, rsp_rdata and rsp_fault stable until rsp_ready. On the handshake edge go to IDLE; the next request can be accepted one cycle later.
- Every accepted request produces exactly one response.
- Address arithmetic is performed in ADDR_WIDTH+1 bits, so a range check that wraps past 2^ADDR_WIDTH reports fault 10.

Optional Feature:
- Macro: DMEM_MISALIGN_SPLIT_EN.
- Defined: misaligned in-range half/word accesses complete with rsp_fault=00 via an extra SPLIT state; latency becomes LATENCY+1.
  - Stores: low-word bytes commit at the acceptance edge, high-word bytes one edge later.
  - Loads: bytes are assembled little-endian across both aligned words.
  - Out-of-range accesses still report fault 10.
- Undefined: misaligned accesses report fault 01, and the SPLIT state is not synthesised.

Test Plan:
- LATENCY=2. Store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid exactly 2 cycles after each acceptance; load rdata=0xDEADBEEF, fault 00.
- Load byte signed @0x13 -> 0xFFFFFFDE. Load byte unsigned @0x13 -> 0x000000DE. Load half signed @0x12 -> 0xFFFFDEAD.
- Store byte 0x55 @0x11, then load word @0x10 -> 0xDEAD55EF (other bytes intact).
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout; a req_valid pulse in that window is not accepted.
- Load word @0x3FE -> fault 10. Load word @0x12 -> fault 01 without macro; with macro, after storing 0x11223344 @0x14, rdata=0x3344DEAD with latency 3. req_mem_read=011 with req_mem_write=11 -> fault 11, no write.
- Assert rst during WAIT -> no rsp_valid, req_ready=1 the cycle after rst deasserts, and the next request completes normally.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the LSU/MEM stage (master) and dmem_ctrl (slave).
interface dmem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [2:0]            req_mem_read;
    logic [1:0]            req_mem_write;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic [1:0]            rsp_fault;

    modport master (
        output req_valid, req_addr, req_wdata, req_mem_read, req_mem_write, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_mem_read, req_mem_write, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte-addressable little-endian data memory, one outstanding request, fixed read latency.
// Define DMEM_MISALIGN_SPLIT_EN to complete misaligned half/word accesses through an extra SPLIT cycle.
module dmem_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int LATENCY     = 2
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus
);
    localparam int                  IDX_W    = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH_BYTES);
    localparam logic [3:0]          CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
`ifdef DMEM_MISALIGN_SPLIT_EN
        , S_SPLIT
`endif
    } state_e;

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic [1:0]       fault_q;
    logic [1:0]       size_q;
    logic             is_load_q;
    logic             sext_q;
    logic [IDX_W-1:0] addr_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic [1:0]       rsp_fault_q;
    logic [7:0]       mem_q [DEPTH_BYTES];
`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [31:0]      wdata_q;
    logic             split_d;
`endif

    logic              accept;
    logic [1:0]        size_code;
    logic [2:0]        size_b;
    logic [ADDR_WIDTH:0] last_addr;
    logic              illegal;
    logic              out_of_range;
    logic              misaligned;
    logic [1:0]        fault_d;
    logic [3:0]        mem_we;
    logic [IDX_W-1:0]  mem_base;
    logic [31:0]       mem_wdata;
    logic [31:0]       rd_raw;
    logic [31:0]       rd_ext;

    assign bus.req_ready = (state_q == S_IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign accept        = bus.req_ready && bus.req_valid;
    assign size_code     = (bus.req_mem_read[1:0] != 2'b00) ? bus.req_mem_read[1:0] : bus.req_mem_write;

    // Selects byte lanes of an access that fall in the first (high=0) or second aligned word.
    function automatic logic lane_hit(input logic [1:0] code, input logic [1:0] base_lo,
                                      input int lane, input logic high);
        logic [2:0] n;
        logic [2:0] pos;
        n   = (code == 2'b01) ? 3'd1 : (code == 2'b10) ? 3'd2 : 3'd4;
        pos = 3'(base_lo) + 3'(lane);
        return (3'(lane) < n) && (pos[2] == high);
    endfunction

    always_comb begin
        case (size_code)
            2'b01:   size_b = 3'd1;
            2'b10:   size_b = 3'd2;
            default: size_b = 3'd4;
        endcase
        illegal = (bus.req_mem_read != 3'b000 && bus.req_mem_write != 2'b00)
               || (bus.req_mem_read == 3'b000 && bus.req_mem_write == 2'b00)
               || (bus.req_mem_read[1:0] == 2'b00 && bus.req_mem_read[2]);
        last_addr    = {1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(size_b) - (ADDR_WIDTH+1)'(1);
        out_of_range = last_addr >= DEPTH_W;
        misaligned   = (size_b == 3'd2 && bus.req_addr[0])
                    || (size_b == 3'd4 && bus.req_addr[1:0] != 2'b00);
`ifdef DMEM_MISALIGN_SPLIT_EN
        split_d = 1'b0;
`endif
        if (illegal)           fault_d = 2'b11;
        else if (out_of_range) fault_d = 2'b10;
        else if (misaligned) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
            fault_d = 2'b00;
            split_d = 1'b1;
`else
            fault_d = 2'b01;
`endif
        end
        else                   fault_d = 2'b00;
    end

    always_comb begin
        mem_we    = 4'b0000;
        mem_base  = bus.req_addr[IDX_W-1:0];
        mem_wdata = bus.req_wdata;
        if (accept && fault_d == 2'b00 && bus.req_mem_write != 2'b00) begin
            for (int i = 0; i < 4; i++) mem_we[i] = lane_hit(size_code, bus.req_addr[1:0], i, 1'b0);
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (state_q == S_SPLIT && !rst && !is_load_q) begin
            mem_base  = addr_q;
            mem_wdata = wdata_q;
            for (int i = 0; i < 4; i++) mem_we[i] = lane_hit(size_q, addr_q[1:0], i, 1'b1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we[i]) mem_q[mem_base + IDX_W'(i)] <= mem_wdata[8*i +: 8];
        end
    end

    always_comb begin
        rd_raw = '0;
        for (int i = 0; i < 4; i++) rd_raw[8*i +: 8] = mem_q[addr_q + IDX_W'(i)];
        case (size_q)
            2'b01:   rd_ext = {{24{sext_q & rd_raw[7]}}, rd_raw[7:0]};
            2'b10:   rd_ext = {{16{sext_q & rd_raw[15]}}, rd_raw[15:0]};
            default: rd_ext = rd_raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            fault_q     <= '0;
            size_q      <= '0;
            is_load_q   <= 1'b0;
            sext_q      <= 1'b0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            wdata_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        fault_q   <= fault_d;
                        size_q    <= size_code;
                        is_load_q <= bus.req_mem_read[1:0] != 2'b00;
                        sext_q    <= bus.req_mem_read[2];
                        addr_q    <= bus.req_addr[IDX_W-1:0];
                        cnt_q     <= CNT_INIT;
`ifdef DMEM_MISALIGN_SPLIT_EN
                        wdata_q   <= bus.req_wdata;
                        state_q   <= split_d ? S_SPLIT : S_WAIT;
`else
                        state_q   <= S_WAIT;
`endif
                    end
                end
`ifdef DMEM_MISALIGN_SPLIT_EN
                S_SPLIT: state_q <= S_WAIT;
`endif
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= fault_q;
                        rsp_rdata_q <= (fault_q == 2'b00 && is_load_q) ? rd_ext : 32'h0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_fault_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus random traffic checked against a byte-array reference model.
module tb_dmem_ctrl;
    localparam int DEPTH = 1024;
    localparam int AW    = 32;
    localparam int LAT   = 2;

    logic       clk = 1'b0;
    logic       rst;
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] ref_mem [DEPTH];

    dmem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    dmem_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int ref_size(input logic [2:0] rd, input logic [1:0] wr);
        logic [1:0] code;
        code = (rd[1:0] != 2'b00) ? rd[1:0] : wr;
        return (code == 2'b01) ? 1 : (code == 2'b10) ? 2 : 4;
    endfunction

    function automatic logic [1:0] ref_fault(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a);
        int sz;
        sz = ref_size(rd, wr);
        if ((rd != 0 && wr != 0) || (rd == 0 && wr == 0) || (rd[1:0] == 0 && rd[2])) return 2'b11;
        if (longint'(a) + longint'(sz) - 1 >= longint'(DEPTH)) return 2'b10;
        if (a % sz != 0) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
            return 2'b00;
`else
            return 2'b01;
`endif
        end
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int sz, input logic sext);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[(a + 32'(i)) % DEPTH]) << (8 * i));
        if (sext && sz == 1) v = 32'($signed(v[7:0]));
        if (sext && sz == 2) v = 32'($signed(v[15:0]));
        return v;
    endfunction

    task automatic txn(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rdata, output logic [1:0] flt, output int lat);
        int w;
        rdata = '0;
        flt   = '0;
        lat   = 0;
        @(negedge clk);
        bus.req_addr      = a;
        bus.req_wdata     = wd;
        bus.req_mem_read  = rd;
        bus.req_mem_write = wr;
        bus.req_valid     = 1'b1;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.rsp_valid) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        rdata = bus.rsp_rdata;
        flt   = bus.rsp_fault;
        for (int c = 0; c < hold; c++) begin
            if (c == 1) begin
                bus.req_addr      = 32'h10;
                bus.req_wdata     = 32'hAAAAAAAA;
                bus.req_mem_read  = 3'b000;
                bus.req_mem_write = 2'b11;
                bus.req_valid     = 1'b1;
            end else begin
                bus.req_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_rdata", bus.rsp_rdata, rdata);
            chk("hold_fault", 32'(bus.rsp_fault), 32'(flt));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic run(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rdata, output logic [1:0] flt);
        logic [1:0]  ef;
        logic [31:0] er;
        int          sz, el, lat;
        sz = ref_size(rd, wr);
        ef = ref_fault(rd, wr, a);
        er = (ef == 2'b00 && rd != 3'b000) ? ref_load(a, sz, rd[2]) : 32'h0;
        el = LAT + ((ef == 2'b00 && a % sz != 0) ? 1 : 0);
        if (ef == 2'b00 && wr != 2'b00) begin
            for (int i = 0; i < sz; i++) ref_mem[(a + 32'(i)) % DEPTH] = wd[8*i +: 8];
        end
        txn(rd, wr, a, wd, hold, rdata, flt, lat);
        chk("rdata", rdata, er);
        chk("fault", 32'(flt), 32'(ef));
        chk("latency", 32'(lat), 32'(el));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [1:0]  f;
        logic [2:0]  rd;
        logic [1:0]  wr;
        logic [31:0] a;
        int          sel;

        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.req_mem_read  = '0;
        bus.req_mem_write = '0;
        bus.rsp_ready     = 1'b0;
        rst               = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_fault", 32'(bus.rsp_fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        for (int k = 0; k < 16; k++) run(3'b000, 2'b11, 32'(4 * k), $urandom, 0, r, f);
        for (int k = 0; k < 4; k++) run(3'b000, 2'b11, 32'h3F0 + 32'(4 * k), $urandom, 0, r, f);

        run(3'b000, 2'b11, 32'h10, 32'hDEADBEEF, 0, r, f);
        chk("sw_rdata_zero", r, 32'h0);
        run(3'b011, 2'b00, 32'h10, 32'h0, 0, r, f);
        chk("lw_10", r, 32'hDEADBEEF);
        run(3'b101, 2'b00, 32'h13, 32'h0, 0, r, f);
        chk("lb_13", r, 32'hFFFFFFDE);
        run(3'b001, 2'b00, 32'h13, 32'h0, 0, r, f);
        chk("lbu_13", r, 32'h000000DE);
        run(3'b110, 2'b00, 32'h12, 32'h0, 0, r, f);
        chk("lh_12", r, 32'hFFFFDEAD);
        run(3'b000, 2'b01, 32'h11, 32'h00000055, 0, r, f);
        run(3'b011, 2'b00, 32'h10, 32'h0, 5, r, f);
        chk("lw_after_sb_hold", r, 32'hDEAD55EF);
        run(3'b011, 2'b00, 32'h10, 32'h0, 0, r, f);
        chk("lw_pulse_ignored", r, 32'hDEAD55EF);
        run(3'b011, 2'b00, 32'h3FE, 32'h0, 0, r, f);
        chk("lw_3fe_fault", 32'(f), 32'd2);
        run(3'b011, 2'b00, 32'hFFFFFFFE, 32'h0, 0, r, f);
        chk("lw_wrap_fault", 32'(f), 32'd2);
`ifdef DMEM_MISALIGN_SPLIT_EN
        run(3'b000, 2'b11, 32'h14, 32'h11223344, 0, r, f);
        run(3'b011, 2'b00, 32'h12, 32'h0, 0, r, f);
        chk("lw_12_split", r, 32'h3344DEAD);
        chk("lw_12_split_fault", 32'(f), 32'd0);
`else
        run(3'b011, 2'b00, 32'h12, 32'h0, 0, r, f);
        chk("lw_12_misaligned", 32'(f), 32'd1);
`endif
        run(3'b011, 2'b11, 32'h10, 32'h12345678, 0, r, f);
        chk("illegal_both", 32'(f), 32'd3);
        run(3'b100, 2'b00, 32'h10, 32'h0, 0, r, f);
        chk("illegal_sext_only", 32'(f), 32'd3);
        run(3'b011, 2'b00, 32'h10, 32'h0, 0, r, f);
        chk("lw_after_illegal", r, 32'hDEAD55EF);

        @(negedge clk);
        bus.req_addr      = 32'h10;
        bus.req_mem_read  = 3'b011;
        bus.req_mem_write = 2'b00;
        bus.req_valid     = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        run(3'b011, 2'b00, 32'h10, 32'h0, 0, r, f);
        chk("lw_after_abort", r, 32'hDEAD55EF);

        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                rd = {1'($urandom_range(0, 1)), 2'($urandom_range(1, 3))};
                wr = 2'b00;
            end else if (sel < 9) begin
                rd = 3'b000;
                wr = 2'($urandom_range(1, 3));
            end else begin
                rd = 3'($urandom_range(0, 7));
                wr = 2'($urandom_range(0, 3));
            end
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = 32'($urandom_range(0, 56));
            else if (sel == 8) a = 32'h3F0 + 32'($urandom_range(0, 15));
            else               a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            run(rd, wr, a, $urandom, $urandom_range(0, 3), r, f);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
